fetch_stage: RTL and testbench

Instruction-fetch stage of the pipelined MIPS core, directly upstream of the instruction memory. Holds the program counter and drives the memory word address. Registers the returned instruction into the IF/ID pipeline register. Handles stall, branch/jump redirect, IF/ID squash and an optional exception vector redirect.

---
 rtl/fetch_stage.sv | 88 ++++++++
 tb/tb_fetch_stage.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, instruction memory address and IF/ID pipeline register.
// Define FETCH_EXCEPTION_EN to honour exc_req (redirect to EXC_VECTOR and capture exc_epc).
module fetch_stage (
   input  logic        clk,
   input  logic        reset,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_instr,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   input  logic        exc_req,
   output logic        ifid_valid,
   output logic [31:0] ifid_instr,
   output logic [31:0] ifid_pc,
   output logic [31:0] ifid_pc_plus4,
   output logic [31:0] exc_epc
);
   localparam logic [31:0] RESET_PC   = 32'h0000_0000;
   localparam logic [31:0] EXC_VECTOR = 32'h8000_0008;
   localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;

   logic [31:0] pc, pc_next, pc_plus4;
   logic        valid_next;
   logic [31:0] instr_next, id_pc_next, id_pc_plus4_next;
   logic        take_exc;

`ifdef FETCH_EXCEPTION_EN
   assign take_exc = exc_req;
`else
   logic unused_inputs;
   assign take_exc      = 1'b0;
   assign unused_inputs = ^{exc_req, redirect_pc[1:0]};
`endif

   assign imem_addr = pc;
   assign pc_plus4  = pc + 32'd4;

   // Next-state selection: exception > redirect > stall > sequential.
   always_comb begin
      pc_next          = pc;
      valid_next       = ifid_valid;
      instr_next       = ifid_instr;
      id_pc_next       = ifid_pc;
      id_pc_plus4_next = ifid_pc_plus4;
      if (take_exc || redirect) begin
         pc_next          = take_exc ? EXC_VECTOR : {redirect_pc[31:2], 2'b00};
         valid_next       = 1'b0;
         instr_next       = NOP_INSTR;
         id_pc_next       = pc;
         id_pc_plus4_next = pc_plus4;
      end else if (!stall) begin
         pc_next          = pc_plus4;
         valid_next       = 1'b1;
         instr_next       = imem_instr;
         id_pc_next       = pc;
         id_pc_plus4_next = pc_plus4;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc            <= RESET_PC;
         ifid_valid    <= 1'b0;
         ifid_instr    <= NOP_INSTR;
         ifid_pc       <= 32'h0;
         ifid_pc_plus4 <= 32'h0;
      end else begin
         pc            <= pc_next;
         ifid_valid    <= valid_next;
         ifid_instr    <= instr_next;
         ifid_pc       <= id_pc_next;
         ifid_pc_plus4 <= id_pc_plus4_next;
      end
   end

`ifdef FETCH_EXCEPTION_EN
   // Return address: the redirect target if one resolves on the same edge, else the faulting fetch PC.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         exc_epc <= 32'h0;
      else if (exc_req)
         exc_epc <= redirect ? redirect_pc : pc;
   end
`else
   assign exc_epc = 32'h0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized stall/redirect/exception traffic
// compared against a behavioural model of the fetch pipeline.
module tb_fetch_stage;
   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] imem_addr, imem_instr;
   logic        stall, redirect, exc_req;
   logic [31:0] redirect_pc;
   logic        ifid_valid;
   logic [31:0] ifid_instr, ifid_pc, ifid_pc_plus4, exc_epc;

   int tests = 0;
   int fails = 0;

   // Reference model state
   logic [31:0] m_pc, m_instr, m_id_pc, m_id_pc4, m_epc;
   logic        m_valid;

   fetch_stage dut (
      .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_instr(imem_instr),
      .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc), .exc_req(exc_req),
      .ifid_valid(ifid_valid), .ifid_instr(ifid_instr), .ifid_pc(ifid_pc),
      .ifid_pc_plus4(ifid_pc_plus4), .exc_epc(exc_epc)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] addr);
      return 32'h1000_0000 + (addr >> 2);
   endfunction

   always_comb imem_instr = mem_word(imem_addr);

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".addr"},  imem_addr, m_pc);
      check({tag, ".valid"}, 32'(ifid_valid), 32'(m_valid));
      check({tag, ".instr"}, ifid_instr, m_instr);
      check({tag, ".pc"},    ifid_pc, m_id_pc);
      check({tag, ".pc4"},   ifid_pc_plus4, m_id_pc4);
      check({tag, ".epc"},   exc_epc, m_epc);
   endtask

   task automatic model_reset();
      m_pc = 32'h0; m_valid = 1'b0; m_instr = 32'h0;
      m_id_pc = 32'h0; m_id_pc4 = 32'h0; m_epc = 32'h0;
   endtask

   // One clock edge with the given inputs; the model advances, then all outputs are compared.
   task automatic step(input string tag, input logic s, input logic r, input logic [31:0] rpc, input logic e);
      logic exc_taken;
      stall = s; redirect = r; redirect_pc = rpc; exc_req = e;
`ifdef FETCH_EXCEPTION_EN
      exc_taken = e;
`else
      exc_taken = 1'b0;
`endif
      @(posedge clk);
      if (exc_taken || r) begin
         if (exc_taken) m_epc = r ? rpc : m_pc;
         m_valid = 1'b0; m_instr = 32'h0;
         m_id_pc = m_pc; m_id_pc4 = m_pc + 32'd4;
         m_pc = exc_taken ? 32'h8000_0008 : (rpc & 32'hFFFF_FFFC);
      end else if (!s) begin
         m_valid = 1'b1; m_instr = mem_word(m_pc);
         m_id_pc = m_pc; m_id_pc4 = m_pc + 32'd4;
         m_pc = m_pc + 32'd4;
      end
      #1;
      check_all(tag);
   endtask

   initial begin
      stall = 0; redirect = 0; redirect_pc = 0; exc_req = 0;
      reset = 1'b1;
      model_reset();
      #12;
      check_all("reset");
      reset = 1'b0;
      @(posedge clk); #1;
      // First edge after release fetches word 0.
      model_reset();
      m_valid = 1'b1; m_instr = 32'h1000_0000; m_id_pc4 = 32'h4; m_pc = 32'h4;
      check_all("first");
      for (int i = 0; i < 3; i++) step("seq", 0, 0, 0, 0);
      check("seq.pc12", ifid_pc, 32'hC);
      check("seq.instr3", ifid_instr, 32'h1000_0003);

      // Stall for three cycles at pc 0x10.
      for (int i = 0; i < 3; i++) step("stall", 1, 0, 0, 0);
      check("stall.addr", imem_addr, 32'h10);
      check("stall.idpc", ifid_pc, 32'hC);
      step("unstall", 0, 0, 0, 0);
      check("unstall.idpc", ifid_pc, 32'h10);
      for (int i = 0; i < 3; i++) step("seq2", 0, 0, 0, 0);

      // Redirect with misaligned target.
      check("pre_redir.addr", imem_addr, 32'h20);
      step("redir", 0, 1, 32'h0000_00E6, 0);
      check("redir.addr", imem_addr, 32'hE4);
      check("redir.valid", 32'(ifid_valid), 32'h0);
      step("redir_tgt", 0, 0, 0, 0);
      check("redir_tgt.idpc", ifid_pc, 32'hE4);

      // Redirect wins over stall.
      step("redir_stall", 1, 1, 32'h0000_0040, 0);
      check("redir_stall.addr", imem_addr, 32'h40);

      // Exception at pc 0x40.
      step("exc", 0, 0, 0, 1);
`ifdef FETCH_EXCEPTION_EN
      check("exc.addr", imem_addr, 32'h8000_0008);
      check("exc.epc", exc_epc, 32'h40);
`else
      check("exc.addr", imem_addr, 32'h44);
      check("exc.epc", exc_epc, 32'h0);
`endif

      // PC wrap.
      step("wrap_redir", 0, 1, 32'hFFFF_FFFF, 0);
      step("wrap", 0, 0, 0, 0);
      check("wrap.addr", imem_addr, 32'h0);
      check("wrap.idpc4", ifid_pc_plus4, 32'h0);

      // No combinational path from inputs to imem_addr.
      redirect = 1'b1; redirect_pc = 32'h1234_5678; exc_req = 1'b1; #2;
      check("nocomb.addr", imem_addr, m_pc);

      // Randomized traffic.
      for (int i = 0; i < 300; i++) begin
         logic [31:0] rpc;
         rpc = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom;
         step("rand", $urandom_range(0, 3) == 0, $urandom_range(0, 6) == 0, rpc,
              $urandom_range(0, 9) == 0);
      end

      // Asynchronous reset in the middle of a cycle.
      @(posedge clk); #3;
      reset = 1'b1; #1;
      model_reset();
      check_all("async_reset");
      #10;
      reset = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
